// File: rtl/stream_resize_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stream_resize_pkg                                                |
// | Brief   : Shared types and helpers for the stream up/down-size converters. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package stream_resize_pkg;

  // Holding-register state shared by both converters.
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    SEND  = 1'b1
  } state_t;

  // Keep must be able to express the value RATIO itself, hence the extra bit.
  function automatic int keep_width(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

  localparam int DEF_T_DATA_RATIO = 3;
  typedef logic [keep_width(DEF_T_DATA_RATIO)-1:0] keep_t;

  // Word counts above the ratio are treated as a full beat.
  function automatic int clamp_keep(input int keep, input int ratio);
    return (keep > ratio) ? ratio : keep;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_downsize.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stream_downsize                                                  |
// | Brief   : Wide-to-narrow stream converter; emits the valid words of each   |
// |           wide beat lowest index first, last on the final word.            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module stream_downsize
  import stream_resize_pkg::*;
#(
  parameter int T_DATA_WIDTH  = 32,
  parameter int T_DATA_RATIO  = 3,
  parameter int T_WIDTH_RATIO = $clog2(T_DATA_RATIO)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_WIDTH_RATIO:0]                    s_keep_i,
  input  logic                                      s_last_i,
  input  logic                                      s_valid_i,
  output logic                                      s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i
);

  localparam int KEEP_W = T_WIDTH_RATIO + 1;
  localparam int IDX_W  = T_WIDTH_RATIO;

  state_t                                    state_q;
  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] data_q;
  logic [KEEP_W-1:0]                         cnt_q;
  logic [IDX_W-1:0]                          idx_q;
  logic                                      last_q;

  logic [KEEP_W-1:0] cnt_d;
  logic [KEEP_W-1:0] last_idx;
  logic              at_end;
  logic              m_hs;
  logic              s_hs;

  // Effective word count of the incoming beat and end-of-beat detection.
  always_comb begin
    cnt_d    = KEEP_W'(clamp_keep(int'(s_keep_i), T_DATA_RATIO));
    last_idx = cnt_q - KEEP_W'(1);
    at_end   = (KEEP_W'(idx_q) == last_idx);
    m_hs     = m_valid_o && m_ready_i;
    s_hs     = s_valid_i && s_ready_o;
  end

  // Upstream may refill the register only when it is empty or the last word leaves now.
  assign s_ready_o = (state_q == EMPTY) || (m_hs && at_end);

  // Narrow outputs come straight from the held register.
  assign m_valid_o = (state_q == SEND);
  assign m_data_o  = data_q[idx_q];
  assign m_last_o  = (state_q == SEND) && last_q && at_end;

  // Holding register, word index and two-state FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          // A zero-keep beat is swallowed along with its last flag.
          if (s_hs && (cnt_d != '0)) begin
            data_q  <= s_data_i;
            cnt_q   <= cnt_d;
            last_q  <= s_last_i;
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (m_hs) begin
            if (!at_end) begin
              idx_q <= idx_q + IDX_W'(1);
            end else if (s_hs && (cnt_d != '0)) begin
              data_q  <= s_data_i;
              cnt_q   <= cnt_d;
              last_q  <= s_last_i;
              idx_q   <= '0;
            end else begin
              state_q <= EMPTY;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_downsize.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_stream_downsize                                               |
// | Brief   : Self-checking bench for stream_downsize.                         |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_stream_downsize;

  localparam int W  = 32;
  localparam int R  = 3;
  localparam int KW = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [R-1:0][W-1:0] s_data;
  logic [KW-1:0]       s_keep;
  logic                s_last;
  logic                s_valid;
  logic                s_ready;
  logic [W-1:0]        m_data;
  logic                m_last;
  logic                m_valid;
  logic                m_ready;

  always #5 clk = ~clk;

  stream_downsize #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data_i (s_data),
    .s_keep_i (s_keep),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One row = inputs for a cycle and the outputs expected in that same cycle.
  typedef struct {
    logic                v;
    logic [R-1:0][W-1:0] d;
    logic [KW-1:0]       k;
    logic                l;
    logic                mr;
    logic                e_sr;
    logic                e_mv;
    logic [W-1:0]        e_md;
    logic                e_ml;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [W-1:0] w0, input logic [W-1:0] w1,
                     input logic [W-1:0] w2, input logic [KW-1:0] k, input logic l,
                     input logic mr, input logic e_sr, input logic e_mv,
                     input logic [W-1:0] e_md, input logic e_ml);
    vec_t t;
    t.v = v; t.d = {w2, w1, w0}; t.k = k; t.l = l; t.mr = mr;
    t.e_sr = e_sr; t.e_mv = e_mv; t.e_md = e_md; t.e_ml = e_ml;
    tbl.push_back(t);
  endtask

  task automatic idle_row(input logic mr);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, mr, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic drive(input logic v, input logic [R-1:0][W-1:0] d, input logic [KW-1:0] k,
                       input logic l, input logic mr);
    s_valid = v; s_data = d; s_keep = k; s_last = l; m_ready = mr;
  endtask

  // Random-phase state.
  logic [W:0]          sb[$];
  logic [W:0]          exp_w;
  logic [R-1:0][W-1:0] rd;
  int                  beats_sent;
  int                  exp_last;
  int                  got_last;
  int                  cyc;
  int                  rk;
  logic                acc;
  logic                prev_stall;
  logic [W-1:0]        sv_data;
  logic                sv_last;

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_ready", W'(s_ready), 32'd1);
    check("reset_m_valid", W'(m_valid), 32'd0);
    check("reset_m_last",  W'(m_last),  32'd0);
    check("reset_m_data",  m_data,      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 5; i++) idle_row(1'b1);
    // Full beat A,B,C keep=3 last=1.
    add(1'b1, 32'hA, 32'hB, 32'hC, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hC, 1'b1);
    idle_row(1'b1);
    // Partial beat keep=2: X must never appear.
    add(1'b1, 32'hA, 32'hB, 32'hEEEE, 3'd2, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB, 1'b1);
    idle_row(1'b1);
    // keep=0 last=1: dropped.
    add(1'b1, 32'h7, 32'h8, 32'h9, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    idle_row(1'b1);
    idle_row(1'b1);
    // Back-to-back 1,2,3 (last=0) then 4,5,6 (last=1), second beat taken during word 3.
    add(1'b1, 32'h1, 32'h2, 32'h3, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2, 1'b0);
    add(1'b1, 32'h4, 32'h5, 32'h6, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'h3, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h5, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h6, 1'b1);
    idle_row(1'b1);
    // keep=5 clamps to 3; sink stalls on the first word.
    add(1'b1, 32'h10, 32'h20, 32'h30, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h30, 1'b1);
    add(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 1'b1);
    idle_row(1'b1);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].mr);
      #1;
      check($sformatf("vec%0d_s_ready", i), W'(s_ready), W'(tbl[i].e_sr));
      check($sformatf("vec%0d_m_valid", i), W'(m_valid), W'(tbl[i].e_mv));
      check($sformatf("vec%0d_m_last", i),  W'(m_last),  W'(tbl[i].e_ml));
      if (tbl[i].e_mv) check($sformatf("vec%0d_m_data", i), m_data, tbl[i].e_md);
    end

    // Reset mid-beat after word A has gone out; a beat offered during reset is discarded.
    @(negedge clk);
    drive(1'b1, {32'hC1, 32'hB1, 32'hA1}, 3'd3, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #1;
    check("rstmid_word_a", m_data, 32'hA1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, {32'h99, 32'h98, 32'h97}, 3'd3, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #1;
    check("rstmid_m_valid", W'(m_valid), 32'd0);
    check("rstmid_s_ready", W'(s_ready), 32'd1);
    @(negedge clk);
    drive(1'b1, {32'hF, 32'hE, 32'hD}, 3'd3, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #1;
    check("rstmid_d", m_data, 32'hD);
    check("rstmid_d_valid", W'(m_valid), 32'd1);
    @(negedge clk); #1;
    check("rstmid_e", m_data, 32'hE);
    @(negedge clk); #1;
    check("rstmid_f", m_data, 32'hF);
    check("rstmid_f_last", W'(m_last), 32'd1);
    @(negedge clk);

    // Random stalls with scoreboard.
    beats_sent = 0; exp_last = 0; got_last = 0; cyc = 0;
    acc = 1'b0; prev_stall = 1'b0; sv_data = '0; sv_last = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    while (!(beats_sent == 200 && !s_valid && sb.size() == 0 && !m_valid)) begin
      if (cyc >= 5000) begin
        check("random_timeout", W'(cyc), 32'd0);
        break;
      end
      @(negedge clk);
      cyc++;
      if (acc) s_valid = 1'b0;
      acc = 1'b0;
      if (!s_valid && beats_sent < 200 && $urandom_range(0, 3) != 0) begin
        for (int j = 0; j < R; j++) rd[j] = $urandom;
        rk = $urandom_range(1, 3);
        drive(1'b1, rd, KW'(rk), 1'($urandom_range(0, 1)), m_ready);
      end
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        check("stall_m_valid", W'(m_valid), 32'd1);
        check("stall_m_data",  m_data,      sv_data);
        check("stall_m_last",  W'(m_last),  W'(sv_last));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("random_unexpected_word", m_data, 32'hDEAD_BEEF);
        end else begin
          exp_w = sb.pop_front();
          check("random_m_data", m_data, exp_w[W-1:0]);
          check("random_m_last", W'(m_last), W'(exp_w[W]));
        end
        if (m_last) got_last++;
      end
      prev_stall = m_valid && !m_ready;
      sv_data = m_data;
      sv_last = m_last;
      if (s_valid && s_ready) begin
        for (int j = 0; j < int'(s_keep); j++)
          sb.push_back({s_last && (j == int'(s_keep) - 1), s_data[j]});
        if (s_last) exp_last++;
        beats_sent++;
        acc = 1'b1;
      end
    end
    check("random_last_count", W'(got_last), W'(exp_last));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
